// File: rtl/kf8253_bus_sequencer_if.sv
// Command/response handshake between an internal agent and the KF8253 bus sequencer.
// The agent side uses the master modport; the sequencer uses the slave modport.
interface kf8253_bus_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [1:0]  cmd_counter;
  logic [2:0]  cmd_mode;
  logic        cmd_bcd;
  logic [15:0] cmd_value;
  logic        rsp_valid;
  logic        rsp_error;
  logic [15:0] rsp_data;

  modport master (
    output cmd_valid, cmd_read, cmd_counter, cmd_mode, cmd_bcd, cmd_value,
    input  cmd_ready, rsp_valid, rsp_error, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_counter, cmd_mode, cmd_bcd, cmd_value,
    output cmd_ready, rsp_valid, rsp_error, rsp_data
  );
endinterface

// File: rtl/kf8253_bus_sequencer.sv
// KF8253 bus sequencer: expands program/read commands into atomic
// control-word / LSB / MSB PIT bus sequences and arbitrates the PIT bus
// against direct CPU accesses, stalling the CPU while a sequence runs.
module kf8253_bus_sequencer #(
  parameter int unsigned STROBE_CYCLES   = 2,
  parameter int unsigned RECOVERY_CYCLES = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  kf8253_bus_sequencer_if.slave        cmd_bus,
  input  logic                         cpu_chip_select_n,
  input  logic                         cpu_read_enable_n,
  input  logic                         cpu_write_enable_n,
  input  logic [1:0]                   cpu_address,
  input  logic [7:0]                   cpu_data_in,
  output logic [7:0]                   cpu_data_out,
  output logic                         cpu_ready,
  output logic                         pit_chip_select_n,
  output logic                         pit_read_enable_n,
  output logic                         pit_write_enable_n,
  output logic [1:0]                   pit_address,
  output logic [7:0]                   pit_data_out,
  input  logic [7:0]                   pit_data_in
);

  // One bus step = strobe phase followed by recovery phase.
  localparam logic [4:0] STROBE_LEN  = 5'(STROBE_CYCLES);
  localparam logic [4:0] STROBE_LAST = 5'(STROBE_CYCLES - 1);
  localparam logic [4:0] PHASE_LAST  = 5'(STROBE_CYCLES + RECOVERY_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  step_reg, step_next;
  logic [4:0]  phase_reg, phase_next;
  logic        read_reg, read_next;
  logic [1:0]  counter_reg, counter_next;
  logic [2:0]  mode_reg, mode_next;
  logic        bcd_reg, bcd_next;
  logic [15:0] value_reg, value_next;   // reload value, or captured count on reads
  logic        rsp_error_reg, rsp_error_next;
  logic [15:0] rsp_data_reg, rsp_data_next;

  logic [1:0]  step_addr;
  logic [7:0]  step_data;
  logic        step_is_read;

  assign cmd_bus.cmd_ready = (state_reg == ST_IDLE) && cpu_chip_select_n;
  assign cmd_bus.rsp_valid = (state_reg == ST_RESP);
  assign cmd_bus.rsp_error = rsp_error_reg;
  assign cmd_bus.rsp_data  = rsp_data_reg;

  // Decode address, data and direction of the current sequence step.
  always_comb begin
    step_addr    = counter_reg;
    step_data    = 8'h00;
    step_is_read = 1'b0;
    case (step_reg)
      2'd0: begin
        step_addr = 2'd3;
        step_data = read_reg ? {counter_reg, 6'b000000}
                             : {counter_reg, 2'b11, mode_reg, bcd_reg};
      end
      2'd1: begin
        step_is_read = read_reg;
        step_data    = read_reg ? 8'h00 : value_reg[7:0];
      end
      default: begin
        step_is_read = read_reg;
        step_data    = read_reg ? 8'h00 : value_reg[15:8];
      end
    endcase
  end

  // Next-state logic: arbitration, step/phase sequencing, read capture, response.
  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    phase_next     = phase_reg;
    read_next      = read_reg;
    counter_next   = counter_reg;
    mode_next      = mode_reg;
    bcd_next       = bcd_reg;
    value_next     = value_reg;
    rsp_error_next = rsp_error_reg;
    rsp_data_next  = rsp_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!cpu_chip_select_n) begin
          state_next = ST_CPU;
        end else if (cmd_bus.cmd_valid) begin
          if (cmd_bus.cmd_counter == 2'd3) begin
            state_next     = ST_RESP;
            rsp_error_next = 1'b1;
            rsp_data_next  = 16'h0000;
          end else begin
            state_next   = ST_ACCESS;
            step_next    = 2'd0;
            phase_next   = 5'd0;
            read_next    = cmd_bus.cmd_read;
            counter_next = cmd_bus.cmd_counter;
            mode_next    = cmd_bus.cmd_mode;
            bcd_next     = cmd_bus.cmd_bcd;
            value_next   = cmd_bus.cmd_value;
          end
        end
      end
      ST_CPU: begin
        if (cpu_chip_select_n) state_next = ST_IDLE;
      end
      ST_ACCESS: begin
        // The PIT drives its data while the read strobe is low; sample on the last strobe clock.
        if (read_reg && (step_reg != 2'd0) && (phase_reg == STROBE_LAST)) begin
          if (step_reg == 2'd1) value_next[7:0]  = pit_data_in;
          else                  value_next[15:8] = pit_data_in;
        end
        if (phase_reg == PHASE_LAST) begin
          phase_next = 5'd0;
          if (step_reg == 2'd2) begin
            state_next     = ST_RESP;
            rsp_error_next = 1'b0;
            rsp_data_next  = read_reg ? value_reg : 16'h0000;
          end else begin
            step_next = step_reg + 2'd1;
          end
        end else begin
          phase_next = phase_reg + 5'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and captured command registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      step_reg      <= 2'd0;
      phase_reg     <= 5'd0;
      read_reg      <= 1'b0;
      counter_reg   <= 2'd0;
      mode_reg      <= 3'd0;
      bcd_reg       <= 1'b0;
      value_reg     <= 16'h0000;
      rsp_error_reg <= 1'b0;
      rsp_data_reg  <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      phase_reg     <= phase_next;
      read_reg      <= read_next;
      counter_reg   <= counter_next;
      mode_reg      <= mode_next;
      bcd_reg       <= bcd_next;
      value_reg     <= value_next;
      rsp_error_reg <= rsp_error_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

  // PIT bus and CPU side outputs: pass-through for the CPU, strobes for a sequence.
  always_comb begin
    pit_chip_select_n  = 1'b1;
    pit_read_enable_n  = 1'b1;
    pit_write_enable_n = 1'b1;
    pit_address        = 2'd0;
    pit_data_out       = 8'h00;
    cpu_data_out       = 8'h00;
    cpu_ready          = 1'b1;
    case (state_reg)
      ST_CPU: begin
        pit_chip_select_n  = cpu_chip_select_n;
        pit_read_enable_n  = cpu_read_enable_n;
        pit_write_enable_n = cpu_write_enable_n;
        pit_address        = cpu_address;
        pit_data_out       = cpu_data_in;
        cpu_data_out       = pit_data_in;
      end
      ST_ACCESS: begin
        pit_address  = step_addr;
        pit_data_out = step_data;
        if (phase_reg < STROBE_LEN) begin
          pit_chip_select_n = 1'b0;
          if (step_is_read) pit_read_enable_n  = 1'b0;
          else              pit_write_enable_n = 1'b0;
        end
        if (!cpu_chip_select_n) cpu_ready = 1'b0;
      end
      ST_RESP: begin
        if (!cpu_chip_select_n) cpu_ready = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/kf8253_bus_sequencer.md
Name: kf8253_bus_sequencer

Overview:
- Bus-side controller placed between the CPU I/O bus and the KF8253 programmable interval timer's CPU interface.
- Lets internal agents (BIOS-less init, speaker/refresh setup) program a counter or read a latched count via a single command handshake.
- Each command expands into atomic multi-byte PIT bus sequences: control word, LSB, MSB.
- Arbitrates the PIT bus against direct CPU accesses and stalls the CPU through cpu_ready while a sequence is in flight.

Parameters:
- STROBE_CYCLES, 2, clocks the PIT strobe (cs_n with rd_n or wr_n) is held low per access; legal range 1..15.
- RECOVERY_CYCLES, 1, clocks all PIT strobes are held high after each access; legal range 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_read  in  1  0 = program counter, 1 = latch-and-read counter.
- cmd_counter  in  2  counter index 0..2; 3 is illegal.
- cmd_mode  in  3  8253 mode, used for program commands.
- cmd_bcd  in  1  BCD bit, used for program commands.
- cmd_value  in  16  reload value, used for program commands.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_error  out  1  qualifies rsp_valid; high for an illegal counter index.
- rsp_data  out  16  latched count for reads; 0 otherwise.
- cpu_chip_select_n, cpu_read_enable_n, cpu_write_enable_n  in  1 each  CPU I/O strobes.
- cpu_address  in  2  CPU port address.
- cpu_data_in  in  8  CPU write data.
- cpu_data_out  out  8  read data returned to the CPU.
- cpu_ready  out  1  low = CPU wait state.
- pit_chip_select_n, pit_read_enable_n, pit_write_enable_n  out  1 each  PIT strobes.
- pit_address  out  2  PIT address.
- pit_data_out  out  8  data to PIT data_bus_in.
- pit_data_in  in  8  data from PIT data_bus_out.

Behaviour:
- Reset:
  - State returns to IDLE.
  - All pit_*_n = 1; pit_address = 0; pit_data_out = 0.
  - cmd_ready = 1 (subject to the CPU gating below); rsp_valid = 0; rsp_error = 0; rsp_data = 0; cpu_ready = 1.
- Reset mid-sequence: strobes go high on the next cycle, no response is produced, and the PIT is reset by the same reset.
- States: IDLE, CPU, ACCESS (with step index 0..2), RESP.
- cmd_ready = (state == IDLE) and cpu_chip_select_n.
- IDLE arbitration:
  - If cpu_chip_select_n = 0, go to CPU. The CPU wins over a simultaneous cmd_valid.
  - Otherwise, on cmd_valid && cmd_ready, capture the command:
    - cmd_counter == 3: go to RESP with rsp_error = 1 and no PIT activity.
    - Else: go to ACCESS, step 0.
- CPU state:
  - All cpu_* inputs pass combinationally to pit_* outputs; cpu_data_out = pit_data_in.
  - Return to IDLE on the first cycle cpu_chip_select_n = 1.
- Outside the CPU state:
  - cpu_data_out = 0.
  - cpu_ready = 0 whenever cpu_chip_select_n = 0 and state is ACCESS or RESP.
  - The stalled CPU cycle is served in the cycle after RESP: IDLE, then CPU.
- ACCESS timing:
  - Each step drives pit_address and pit_data_out stable for STROBE_CYCLES + RECOVERY_CYCLES clocks.
  - pit_chip_select_n and the relevant rd/wr strobe are low for the first STROBE_CYCLES clocks.
  - A phase counter sequences the strobe and recovery phases.
- Program sequence:
  - Step 0: address 3, data {counter, 2'b11, mode, bcd}.
  - Step 1: address = counter, data = value[7:0].
  - Step 2: address = counter, data = value[15:8].
- Read sequence:
  - Step 0: address 3, data {counter, 6'b000000} (latch command).
  - Step 1: read at address = counter; pit_data_in is captured into rsp_data[7:0] on the last strobe clock.
  - Step 2: the same read; capture goes into rsp_data[15:8].
- Sequences are atomic. The CPU never interleaves between steps, which protects the PIT LSB/MSB toggle.
- Latency: command accepted at edge T; the first strobe is low in cycle T+1.
  - rsp_valid is high for exactly one cycle at T+1+3*(S+R), where S = STROBE_CYCLES and R = RECOVERY_CYCLES; then IDLE.
  - With defaults this is T+10.
- rsp_data and rsp_error hold their values until the next rsp_valid.
- Program completion returns rsp_data = 0.

Test Plan:
- Program counter 0, mode 3, value 0x1234, defaults:
  - PIT writes in order: addr3 = 0x36, addr0 = 0x34, addr0 = 0x12.
  - Each write has a 2-clock strobe and 1 clock of recovery.
  - rsp_valid pulses at T+10 with rsp_error = 0.
- Read counter 2 with the PIT returning 0xCD then 0xAB:
  - Latch write addr3 = 0x80, then two reads at addr2.
  - rsp_data = 0xABCD at T+10.
- cmd_counter = 3:
  - No PIT strobe toggles.
  - rsp_valid and rsp_error = 1 one cycle after accept.
- CPU chip select low during step 1 of a program command:
  - cpu_ready = 0 until RESP; the sequence completes unbroken.
  - The CPU strobes appear on the pit_* outputs two cycles after rsp_valid.
- cmd_valid and cpu_chip_select_n asserted in the same IDLE cycle:
  - CPU is served first; cmd_ready = 0.
  - The command is accepted in the cycle after cpu_chip_select_n returns high.
- Reset asserted during step 2:
  - Next cycle all pit_*_n = 1, no rsp_valid, cmd_ready = 1.
